mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the single-port instruction/data memory bus.
- Master 0 is the instruction fetch unit; master 1 is the load/store unit or program loader.
- Slave side drives the memory block: 1-cycle registered read latency, grant equals request.
- Round-robin arbitration with an optional bounded-burst lock. Read data is routed back to the requester that issued the read.

---
 rtl/mem_bus_pkg.sv | 13 +
 rtl/rr_arb2.sv | 58 +++++
 rtl/mem_bus_arbiter.sv | 73 +++++++
 tb/tb_mem_bus_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and master identifiers for the instruction/data memory bus.
package mem_bus_pkg;
  localparam int PKG_AW      = 32;
  localparam int PKG_DW      = 32;
  localparam int NUM_MASTERS = 2;

  typedef logic [PKG_AW-1:0] addr_t;
  typedef logic [PKG_DW-1:0] data_t;
  typedef logic              master_id_t;

  localparam master_id_t M_IFETCH = 1'b0;
  localparam master_id_t M_LSU    = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with a bounded burst lock held by the current owner.
module rr_arb2
  import mem_bus_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] lock,
  output master_id_t             winner,
  output logic                   valid
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t MAX_CNT = cnt_t'(MAX_BURST);

  master_id_t last_winner;
  master_id_t owner;
  logic       owner_vld;
  cnt_t       burst_cnt;
  logic       lock_act;

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c >= MAX_CNT) ? MAX_CNT : c + cnt_t'(1);
  endfunction

  // Once the burst count saturates the lock drops out and round-robin hands over.
  always_comb begin
    lock_act = owner_vld && lock[owner] && req[owner] && (burst_cnt < MAX_CNT);
    valid    = rst_n && (|req);
    winner   = M_IFETCH;
    if (lock_act)
      winner = owner;
    else if (req[0] && req[1])
      winner = ~last_winner;
    else if (req[1])
      winner = M_LSU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner <= M_LSU;
      owner       <= M_IFETCH;
      owner_vld   <= 1'b0;
      burst_cnt   <= '0;
    end else if (valid) begin
      last_winner <= winner;
      owner       <= winner;
      owner_vld   <= 1'b1;
      burst_cnt   <= (owner_vld && (owner == winner) && lock[winner])
                     ? sat_inc(burst_cnt) : cnt_t'(1);
    end else begin
      owner_vld   <= 1'b0;
      burst_cnt   <= '0;
    end
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single-port memory; routes 1-cycle read data back to the issuer.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_MASTERS-1:0]          m_req,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS-1:0]          m_lock,
  input  logic [NUM_MASTERS-1:0][AW-1:0]  m_addr,
  input  logic [NUM_MASTERS-1:0][DW-1:0]  m_wdata,
  output logic [NUM_MASTERS-1:0]          m_gnt,
  output logic [NUM_MASTERS-1:0]          m_rvalid,
  output logic [NUM_MASTERS-1:0][DW-1:0]  m_rdata,
  output logic                            s_req,
  output logic                            s_we,
  output logic [AW-1:0]                   s_addr,
  output logic [DW-1:0]                   s_wdata,
  input  logic [DW-1:0]                   s_rdata
);
  master_id_t winner;
  logic       valid;
  logic       rsp_pending;
  master_id_t rsp_sel;

  rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (m_req),
    .lock   (m_lock),
    .winner (winner),
    .valid  (valid)
  );

  always_comb begin
    m_gnt   = '0;
    s_req   = valid;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (valid) begin
      m_gnt[winner] = 1'b1;
      s_we          = m_we[winner];
      s_addr        = m_addr[winner];
      s_wdata       = m_wdata[winner];
    end
  end

  // Slave latency is fixed at one cycle, so one tag register is enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pending <= 1'b0;
      rsp_sel     <= M_IFETCH;
    end else begin
      rsp_pending <= valid && !m_we[winner];
      if (valid && !m_we[winner])
        rsp_sel <= winner;
    end
  end

  always_comb begin
    m_rvalid = '0;
    m_rdata  = '0;
    if (rsp_pending) begin
      m_rvalid[rsp_sel] = 1'b1;
      m_rdata[rsp_sel]  = s_rdata;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter against a behavioural bus model.
module tb_mem_bus_arbiter;
  localparam int MAXB = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       m_req, m_we, m_lock;
  logic [1:0][31:0] m_addr, m_wdata;
  logic [1:0]       m_gnt, m_rvalid;
  logic [1:0][31:0] m_rdata;
  logic             s_req, s_we;
  logic [31:0]      s_addr, s_wdata, s_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  mem_bus_arbiter #(.AW(32), .DW(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_lock(m_lock),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h0070_8093;
  endfunction

  // Slave memory: registered read of the bus address, garbage otherwise.
  always @(posedge clk) begin
    if (s_req && !s_we) s_rdata <= mem_val(s_addr);
    else                s_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: who owns the bus, how long, and which read is outstanding.
  int          mdl_last, mdl_owner, mdl_cnt, mdl_sel;
  bit          mdl_pend;
  logic [31:0] mdl_paddr;

  function automatic int exp_winner();
    if (m_req == 2'b00) return -1;
    if (m_req == 2'b01) return 0;
    if (m_req == 2'b10) return 1;
    if (mdl_owner >= 0 && m_lock[mdl_owner]) begin
      if (mdl_cnt < MAXB) return mdl_owner;
      return 1 - mdl_owner;
    end
    return 1 - mdl_last;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      mdl_last <= 1; mdl_owner <= -1; mdl_cnt <= 0;
      mdl_pend <= 1'b0; mdl_sel <= 0; mdl_paddr <= '0;
    end else begin
      w = exp_winner();
      if (w < 0) begin
        mdl_owner <= -1; mdl_cnt <= 0; mdl_pend <= 1'b0;
      end else begin
        if (w == mdl_owner && m_lock[w]) mdl_cnt <= (mdl_cnt + 1 > MAXB) ? MAXB : mdl_cnt + 1;
        else                              mdl_cnt <= 1;
        mdl_owner <= w;
        mdl_last  <= w;
        mdl_pend  <= !m_we[w];
        mdl_sel   <= w;
        mdl_paddr <= m_addr[w];
      end
    end
  end

  logic [1:0]  e_gnt, e_rv;
  logic        e_req, e_we;
  logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
  int          e_w;

  always @(negedge clk) begin
    e_gnt = '0; e_rv = '0; e_req = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wd = '0; e_rd0 = '0; e_rd1 = '0;
    if (rst_n) begin
      e_w = exp_winner();
      if (e_w >= 0) begin
        e_gnt[e_w] = 1'b1; e_req = 1'b1; e_we = m_we[e_w];
        e_addr = m_addr[e_w]; e_wd = m_wdata[e_w];
      end
      if (mdl_pend) begin
        e_rv[mdl_sel] = 1'b1;
        if (mdl_sel == 0) e_rd0 = mem_val(mdl_paddr);
        else              e_rd1 = mem_val(mdl_paddr);
      end
    end
    chk("m_gnt", 64'(m_gnt), 64'(e_gnt));
    chk("s_req", 64'(s_req), 64'(e_req));
    chk("s_we", 64'(s_we), 64'(e_we));
    chk("s_addr", 64'(s_addr), 64'(e_addr));
    chk("s_wdata", 64'(s_wdata), 64'(e_wd));
    chk("m_rvalid", 64'(m_rvalid), 64'(e_rv));
    chk("m_rdata0", 64'(m_rdata[0]), 64'(e_rd0));
    chk("m_rdata1", 64'(m_rdata[1]), 64'(e_rd1));
  end

  task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic [1:0] lock,
                       input logic [31:0] a0, input logic [31:0] a1);
    m_req = req; m_we = we; m_lock = lock;
    m_addr[0] = a0; m_addr[1] = a1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [1:0] lock_seq_exp [6];

  initial begin
    rst_n = 1'b0;
    m_wdata[0] = 32'h1111_0000; m_wdata[1] = 32'hDEAD_BEEF;
    drive(2'b11, 2'b00, 2'b11, 32'h4, 32'h8);
    @(negedge clk);
    chk("reset_gnt", 64'(m_gnt), 64'h0);
    chk("reset_sreq", 64'(s_req), 64'h0);
    tick();
    drive(2'b00, 2'b00, 2'b00, 0, 0);
    rst_n = 1'b1;

    // Single reads on separate cycles.
    drive(2'b01, 2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk); chk("single0_gnt", 64'(m_gnt), 64'h1);
    tick();
    drive(2'b10, 2'b00, 2'b00, 32'h0, 32'h8);
    @(negedge clk); chk("single1_gnt", 64'(m_gnt), 64'h2);
    chk("single0_rv", 64'(m_rvalid), 64'h1);
    chk("single0_rd", 64'(m_rdata[0]), 64'h0070_8093);
    tick();
    drive(2'b00, 2'b00, 2'b00, 0, 0);
    @(negedge clk); chk("single1_rv", 64'(m_rvalid), 64'h2);
    chk("single1_rd", 64'(m_rdata[1]), 64'h0070_809B);
    chk("single1_rd0", 64'(m_rdata[0]), 64'h0);
    tick();

    // Contention without lock alternates, starting with m0.
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b00, 2'b00, 32'h100 + 32'(i * 4), 32'h200 + 32'(i * 4));
      @(negedge clk); chk("rr_gnt", 64'(m_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end

    // Locked burst by m1 with m0 competing; one m0 grant first so m1 wins next.
    drive(2'b01, 2'b00, 2'b00, 32'h300, 0);
    tick();
    lock_seq_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 2'b00, 2'b10, 32'h400, 32'h500 + 32'(i * 4));
      @(negedge clk); chk("burst_gnt", 64'(m_gnt), 64'(lock_seq_exp[i]));
      tick();
    end

    // Write from m1 and read from m0 contend with last winner m0.
    drive(2'b01, 2'b00, 2'b00, 32'h600, 0);
    tick();
    drive(2'b00, 2'b00, 2'b00, 0, 0);
    tick();
    drive(2'b11, 2'b10, 2'b00, 32'h700, 32'h10);
    @(negedge clk); chk("wr_gnt", 64'(m_gnt), 64'h2);
    chk("wr_swe", 64'(s_we), 64'h1);
    chk("wr_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
    chk("wr_addr", 64'(s_addr), 64'h10);
    tick();
    drive(2'b01, 2'b00, 2'b00, 32'h700, 0);
    @(negedge clk); chk("after_wr_gnt", 64'(m_gnt), 64'h1);
    chk("after_wr_rv", 64'(m_rvalid), 64'h0);
    tick();
    drive(2'b00, 2'b00, 2'b00, 0, 0);
    @(negedge clk); chk("rd_after_wr_rv", 64'(m_rvalid), 64'h1);
    tick();

    // Reset lands between a granted read and its response.
    drive(2'b10, 2'b00, 2'b00, 0, 32'h20);
    @(negedge clk); chk("rstmid_gnt", 64'(m_gnt), 64'h2);
    #2 rst_n = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 32'h24, 32'h28);
    tick();
    @(negedge clk); chk("rstmid_rv", 64'(m_rvalid), 64'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk); chk("post_rst_gnt", 64'(m_gnt), 64'h1);
    chk("post_rst_rv", 64'(m_rvalid), 64'h0);
    tick();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      m_req     = 2'($urandom_range(0, 3));
      m_we      = {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)};
      m_lock    = {($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6)};
      m_addr[0] = $urandom & 32'hFFFF_FFFC;
      m_addr[1] = $urandom & 32'hFFFF_FFFC;
      m_wdata[0] = $urandom;
      m_wdata[1] = $urandom;
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end

    drive(2'b00, 2'b00, 2'b00, 0, 0);
    tick(); tick();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
